// File: rtl/ahb_slave_response_mux_if.sv
// rtl/ahb_slave_response_mux_if.sv - AHB response-mux bus bundle with master/slave views
//
// Purpose : groups the decoder selects, master transfer type, per-slave
//           responses and the muxed master-facing responses of the
//           AHB slave response mux.
// Ports   : slave modport  - view used by ahb_slave_response_mux
//                            (selects/slave responses in, muxed responses out)
//           master modport - view used by whatever drives the mux
//                            (decoder/master/slaves side)
interface ahb_slave_response_mux_if #(
   parameter int AHB_NUM_SLAVES = 4,
   parameter int DATAWIDTH      = 32,
   parameter int CNTWIDTH       = 16
);
   logic [AHB_NUM_SLAVES-1:0]           HSEL;
   logic [1:0]                          HTRANS;
   logic [AHB_NUM_SLAVES*DATAWIDTH-1:0] HRDATA_S;
   logic [AHB_NUM_SLAVES-1:0]           HREADYOUT_S;
   logic [AHB_NUM_SLAVES-1:0]           HRESP_S;
   logic [DATAWIDTH-1:0]                HRDATA;
   logic                                HREADY;
   logic                                HRESP;
   logic                                SEL_MULTI;
   logic [CNTWIDTH-1:0]                 DEF_ERR_COUNT;

   modport slave (
      input  HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
      output HRDATA, HREADY, HRESP, SEL_MULTI, DEF_ERR_COUNT
   );

   modport master (
      output HSEL, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
      input  HRDATA, HREADY, HRESP, SEL_MULTI, DEF_ERR_COUNT
   );
endinterface

// File: rtl/ahb_slave_response_mux.sv
// rtl/ahb_slave_response_mux.sv - AHB data-phase response mux with integrated default slave
//
// Purpose : registers the data-phase owner on every address-phase capture
//           (HREADY=1) and routes the owner's HRDATA/HREADYOUT/HRESP to the
//           master. Unmapped active transfers are answered by a built-in
//           default slave with the two-cycle ERROR response, and counted.
// Ports   : HCLK   - bus clock, rising edge
//           HRESET - synchronous, active-high reset
//           bus    - slave view of ahb_slave_response_mux_if:
//                    HSEL/HTRANS/HRDATA_S/HREADYOUT_S/HRESP_S in,
//                    HRDATA/HREADY/HRESP/SEL_MULTI/DEF_ERR_COUNT out
module ahb_slave_response_mux #(
   parameter int AHB_NUM_SLAVES = 4,
   parameter int DATAWIDTH      = 32,
   parameter int CNTWIDTH       = 16
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   ahb_slave_response_mux_if.slave       bus
);
   localparam int OW = (AHB_NUM_SLAVES > 1) ? $clog2(AHB_NUM_SLAVES) : 1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   ds_state_t             r_state;
   logic                  r_def_owner;   // default slave owns the data phase
   logic [OW-1:0]         r_owner;       // owning slave index when !r_def_owner
   logic                  r_sel_multi;
   logic [CNTWIDTH-1:0]   r_err_cnt;

   logic [OW-1:0]         w_low_idx;
   logic                  w_any_sel;
   logic                  w_multi_sel;
   logic                  w_unmapped_active;
   logic                  w_hready;
   logic                  w_hresp;
   logic [DATAWIDTH-1:0]  w_hrdata;
   logic                  w_unused_htrans0;

   assign w_unused_htrans0 = bus.HTRANS[0];

   // Lowest set select wins; a second set bit flags a decoder overlap.
   always_comb begin
      w_low_idx   = '0;
      w_any_sel   = 1'b0;
      w_multi_sel = 1'b0;
      for (int k = 0; k < AHB_NUM_SLAVES; k++) begin
         if (bus.HSEL[k]) begin
            if (w_any_sel) begin
               w_multi_sel = 1'b1;
            end else begin
               w_low_idx = OW'(k);
            end
            w_any_sel = 1'b1;
         end
      end
   end

   assign w_unmapped_active = !w_any_sel && bus.HTRANS[1];

   // Data-phase routing depends only on registered owner/state plus slave
   // responses, so HSEL/HTRANS never reach the master outputs combinationally.
   always_comb begin
      w_hready = 1'b1;
      w_hresp  = 1'b0;
      w_hrdata = '0;
      if (r_def_owner) begin
         w_hready = (r_state != DS_ERR1);
         w_hresp  = (r_state != DS_IDLE);
      end else begin
         for (int k = 0; k < AHB_NUM_SLAVES; k++) begin
            if (r_owner == OW'(k)) begin
               w_hready = bus.HREADYOUT_S[k];
               w_hresp  = bus.HRESP_S[k];
               w_hrdata = bus.HRDATA_S[k*DATAWIDTH +: DATAWIDTH];
            end
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state     <= DS_IDLE;
         r_def_owner <= 1'b1;
         r_owner     <= '0;
         r_sel_multi <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_sel_multi <= 1'b0;

         if (w_hready) begin
            r_def_owner <= !w_any_sel;
            if (w_any_sel) begin
               r_owner     <= w_low_idx;
               r_sel_multi <= w_multi_sel;
            end
         end

         case (r_state)
            DS_IDLE: begin
               if (w_hready && w_unmapped_active) begin
                  r_state <= DS_ERR1;
               end
            end
            DS_ERR1: begin
               // Count on entry to ERR2 so the count is visible while the
               // ERROR response completes; saturate instead of wrapping.
               r_state <= DS_ERR2;
               if (r_err_cnt != {CNTWIDTH{1'b1}}) begin
                  r_err_cnt <= r_err_cnt + CNTWIDTH'(1);
               end
            end
            DS_ERR2: begin
               // HREADY is high here, so this edge is also a capture edge.
               r_state <= w_unmapped_active ? DS_ERR1 : DS_IDLE;
            end
            default: begin
               r_state <= DS_IDLE;
            end
         endcase
      end
   end

   assign bus.HREADY        = w_hready;
   assign bus.HRESP         = w_hresp;
   assign bus.HRDATA        = w_hrdata;
   assign bus.SEL_MULTI     = r_sel_multi;
   assign bus.DEF_ERR_COUNT = r_err_cnt;

endmodule

// File: tb/tb_ahb_slave_response_mux.sv
// tb/tb_ahb_slave_response_mux.sv - self-checking bench for ahb_slave_response_mux
module tb_ahb_slave_response_mux;
   localparam int NS = 4;
   localparam int DW = 32;
   localparam int CW = 4;

   logic HCLK = 1'b0;
   logic HRESET;

   always #5 HCLK = ~HCLK;

   ahb_slave_response_mux_if #(.AHB_NUM_SLAVES(NS), .DATAWIDTH(DW), .CNTWIDTH(CW)) bus ();

   ahb_slave_response_mux #(.AHB_NUM_SLAVES(NS), .DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Expected outputs; -1 in any field means "not checked".
   typedef struct {
      string  name;
      int     hready;
      int     hresp;
      longint hrdata;
      int     multi;
      int     cnt;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      string       name;
      logic [3:0]  hsel;
      logic [1:0]  htrans;
      logic [3:0]  rdy;
      logic [3:0]  resp;
      int          e_ready;
      int          e_resp;
      longint      e_data;
      int          e_multi;
   } vec_t;

   vec_t vt[9];

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   task automatic push(input string n, input int r, input int s, input longint d,
                       input int m, input int c);
      exp_t e;
      e.name   = n;
      e.hready = r;
      e.hresp  = s;
      e.hrdata = d;
      e.multi  = m;
      e.cnt    = c;
      sb.push_back(e);
   endtask

   task automatic cmp(input string n, input string f, input longint act, input longint exp);
      if (exp >= 0) begin
         checks++;
         if (act != exp) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h expected=0x%0h", n, f, act, exp);
         end
      end
   endtask

   task automatic pop_check();
      exp_t e;
      #2;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
         e = sb.pop_front();
         cmp(e.name, "HREADY",        longint'(bus.HREADY),        longint'(e.hready));
         cmp(e.name, "HRESP",         longint'(bus.HRESP),         longint'(e.hresp));
         cmp(e.name, "HRDATA",        longint'(bus.HRDATA),        e.hrdata);
         cmp(e.name, "SEL_MULTI",     longint'(bus.SEL_MULTI),     longint'(e.multi));
         cmp(e.name, "DEF_ERR_COUNT", longint'(bus.DEF_ERR_COUNT), longint'(e.cnt));
      end
   endtask

   task automatic addr(input logic [3:0] hsel, input logic [1:0] htrans);
      bus.HSEL   = hsel;
      bus.HTRANS = htrans;
   endtask

   initial begin
      // slave k returns (k+1) replicated in every nibble
      vt[0] = '{"s0_route",   4'b0001, T_NONSEQ, 4'b1111, 4'b0000, 1, 0, 64'h11111111, 0};
      vt[1] = '{"s2_wait",    4'b0100, T_NONSEQ, 4'b1011, 4'b0000, 0, 0, 64'h33333333, 0};
      vt[2] = '{"s3_err",     4'b1000, T_NONSEQ, 4'b1111, 4'b1000, 1, 1, 64'h44444444, 0};
      vt[3] = '{"multi_1010", 4'b1010, T_NONSEQ, 4'b1111, 4'b0000, 1, 0, 64'h22222222, 1};
      vt[4] = '{"multi_1111", 4'b1111, T_NONSEQ, 4'b1111, 4'b0001, 1, 1, 64'h11111111, 1};
      vt[5] = '{"def_idle",   4'b0000, T_IDLE,   4'b0000, 4'b1111, 1, 0, 64'h0,        0};
      vt[6] = '{"def_busy",   4'b0000, T_BUSY,   4'b0000, 4'b1111, 1, 0, 64'h0,        0};
      vt[7] = '{"s1_htidle",  4'b0010, T_IDLE,   4'b1111, 4'b0000, 1, 0, 64'h22222222, 0};
      vt[8] = '{"multi_wait", 4'b0110, T_NONSEQ, 4'b1101, 4'b0000, 0, 0, 64'h22222222, 1};

      HRESET          = 1'b1;
      bus.HSEL        = '0;
      bus.HTRANS      = T_IDLE;
      bus.HREADYOUT_S = 4'b1111;
      bus.HRESP_S     = 4'b0000;
      bus.HRDATA_S    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

      // Reset hold and release
      repeat (2) @(negedge HCLK);
      push("rst_hold", 1, 0, 0, 0, 0);
      pop_check();
      HRESET = 1'b0;
      @(negedge HCLK);
      push("rst_release", 1, 0, 0, 0, 0);
      pop_check();

      // Table-driven single-transfer routing
      for (int i = 0; i < 9; i++) begin
         @(negedge HCLK);
         addr(vt[i].hsel, vt[i].htrans);
         bus.HREADYOUT_S = 4'b1111;
         bus.HRESP_S     = 4'b0000;
         @(negedge HCLK);
         addr(4'b0000, T_IDLE);
         bus.HREADYOUT_S = vt[i].rdy;
         bus.HRESP_S     = vt[i].resp;
         push(vt[i].name, vt[i].e_ready, vt[i].e_resp, vt[i].e_data, vt[i].e_multi, 0);
         pop_check();
         @(negedge HCLK);
         bus.HREADYOUT_S = 4'b1111;
         bus.HRESP_S     = 4'b0000;
         push({vt[i].name, "_mclr"}, -1, -1, -1, 0, -1);
         pop_check();
         @(negedge HCLK);
      end

      // Slave 1 inserts two wait states then returns data
      @(negedge HCLK);
      addr(4'b0010, T_NONSEQ);
      @(negedge HCLK);
      addr(4'b0000, T_IDLE);
      bus.HREADYOUT_S = 4'b1101;
      push("ws_wait1", 0, 0, -1, 0, 0);
      pop_check();
      @(negedge HCLK);
      push("ws_wait2", 0, 0, -1, 0, 0);
      pop_check();
      @(negedge HCLK);
      bus.HREADYOUT_S = 4'b1111;
      bus.HRDATA_S[1*DW +: DW] = 32'hDEADBEEF;
      push("ws_done", 1, 0, 64'hDEADBEEF, 0, 0);
      pop_check();
      @(negedge HCLK);
      bus.HRDATA_S[1*DW +: DW] = 32'h22222222;
      push("ws_after", 1, 0, 0, 0, 0);
      pop_check();

      // Single unmapped NONSEQ: two-cycle ERROR
      @(negedge HCLK);
      addr(4'b0000, T_NONSEQ);
      @(negedge HCLK);
      addr(4'b0000, T_IDLE);
      push("err_c1", 0, 1, 0, 0, 0);
      pop_check();
      @(negedge HCLK);
      push("err_c2", 1, 1, 0, 0, 1);
      pop_check();
      @(negedge HCLK);
      push("err_done", 1, 0, 0, 0, 1);
      pop_check();

      // Back-to-back unmapped: second address presented through ERR1/ERR2
      @(negedge HCLK);
      addr(4'b0000, T_NONSEQ);
      @(negedge HCLK);
      push("b2b_err1a", 0, 1, 0, 0, 1);
      pop_check();
      @(negedge HCLK);
      push("b2b_err2a", 1, 1, 0, 0, 2);
      pop_check();
      @(negedge HCLK);
      addr(4'b0000, T_IDLE);
      push("b2b_err1b", 0, 1, 0, 0, 2);
      pop_check();
      @(negedge HCLK);
      push("b2b_err2b", 1, 1, 0, 0, 3);
      pop_check();
      @(negedge HCLK);
      push("b2b_done", 1, 0, 0, 0, 3);
      pop_check();

      // Reset asserted during ERR1 aborts the ERROR sequence
      @(negedge HCLK);
      addr(4'b0000, T_NONSEQ);
      @(negedge HCLK);
      addr(4'b0000, T_IDLE);
      push("rst_err1", 0, 1, 0, 0, 3);
      pop_check();
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      push("rst_abort", 1, 0, 0, 0, 0);
      pop_check();
      @(negedge HCLK);
      push("rst_abort_next", 1, 0, 0, 0, 0);
      pop_check();

      // Saturation: continuous unmapped NONSEQ, 4-bit counter
      @(negedge HCLK);
      addr(4'b0000, T_NONSEQ);
      repeat (30) @(negedge HCLK);
      push("sat_at_max", 1, 1, 0, 0, 15);
      pop_check();
      repeat (4) @(negedge HCLK);
      push("sat_hold", 1, 1, 0, 0, 15);
      pop_check();
      addr(4'b0000, T_IDLE);
      @(negedge HCLK);
      push("sat_idle", 1, 0, 0, 0, 15);
      pop_check();

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
